// File: rtl/cdb_arbiter.sv
// cdb_arbiter: one holding slot per result producer (ALU, MEM, BCU) and a
// round-robin scheduler that broadcasts one (rob_id, value) per cycle on the CDB.
module cdb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ROB_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      flush_in,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ROB_W-1:0]  req_rob_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_value,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ROB_W-1:0]          cdb_rob_id,
    output logic [DATA_W-1:0]         cdb_value,
    output logic [1:0]                cdb_src,
    output logic [1:0]                pending_count
);
    // The 2-bit cdb_src port bounds the design to at most four requesters.
    localparam int PTR_W = 2;

    logic [NUM_REQ-1:0] r_occ;
    logic [ROB_W-1:0]   r_rob [NUM_REQ];
    logic [DATA_W-1:0]  r_val [NUM_REQ];
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [ROB_W-1:0]   r_cdb_rob;
    logic [DATA_W-1:0]  r_cdb_val;
    logic [PTR_W-1:0]   r_cdb_src;
    logic [1:0]         r_pend;

    logic               w_any_grant;
    logic [PTR_W-1:0]   w_grant;
    logic [PTR_W-1:0]   w_scan;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [NUM_REQ-1:0] w_capture;
    logic [NUM_REQ-1:0] w_occ_nxt;
    logic [1:0]         w_pend_nxt;
    logic [PTR_W-1:0]   w_ptr_nxt;

    // Round-robin search starting at r_rr_ptr; the first occupied slot wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        w_any_grant = 1'b0;
        w_grant     = '0;
        w_grant_oh  = '0;
        w_scan      = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any_grant && r_occ[w_scan]) begin
                w_any_grant        = 1'b1;
                w_grant            = w_scan;
                w_grant_oh[w_scan] = 1'b1;
            end
            w_scan = (w_scan == PTR_W'(NUM_REQ - 1)) ? '0 : w_scan + PTR_W'(1);
        end
    end

    // Ready ignores req_valid, so there is no combinational path valid -> ready.
    always_comb begin
        req_ready  = '0;
        w_capture  = '0;
        w_occ_nxt  = r_occ;
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !flush_in && (!r_occ[i] || w_grant_oh[i]);
            w_capture[i] = req_valid[i] && req_ready[i] && (req_rob_id[i*ROB_W +: ROB_W] != '0);
            if (flush_in)
                w_occ_nxt[i] = 1'b0;
            else if (w_capture[i])
                w_occ_nxt[i] = 1'b1;
            else if (w_grant_oh[i])
                w_occ_nxt[i] = 1'b0;
            if (w_occ_nxt[i])
                w_pend_nxt = w_pend_nxt + 2'd1;
        end
        w_ptr_nxt = (w_grant == PTR_W'(NUM_REQ - 1)) ? '0 : w_grant + PTR_W'(1);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_occ     <= '0;
            r_rr_ptr  <= '0;
            r_cdb_rob <= '0;
            r_cdb_val <= '0;
            r_cdb_src <= '0;
            r_pend    <= '0;
        end else begin
            r_occ  <= w_occ_nxt;
            r_pend <= w_pend_nxt;
            if (flush_in) begin
                r_cdb_rob <= '0;
                r_rr_ptr  <= '0;
            end else if (w_any_grant) begin
                r_cdb_rob <= r_rob[w_grant];
                r_cdb_val <= r_val[w_grant];
                r_cdb_src <= w_grant;
                r_rr_ptr  <= w_ptr_nxt;
            end else begin
                r_cdb_rob <= '0;
            end
        end
    end

    // NOTE: slot payload has no reset; it is only ever read while r_occ marks it valid.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_capture[i]) begin
                r_rob[i] <= req_rob_id[i*ROB_W +: ROB_W];
                r_val[i] <= req_value[i*DATA_W +: DATA_W];
            end
        end
    end

    assign cdb_rob_id    = r_cdb_rob;
    assign cdb_value     = r_cdb_val;
    assign cdb_src       = r_cdb_src;
    assign pending_count = r_pend;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a per-cycle vector table plus
// hand-written streaming, rob-id-zero and asynchronous-reset sequences.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ROB_W   = 5;
    localparam int DATA_W  = 32;

    // Each requester's value is its base plus the rob id, so the value also names the source.
    localparam logic [31:0] BASE0 = 32'hA000_0000;
    localparam logic [31:0] BASE1 = 32'hB000_0000;
    localparam logic [31:0] BASE2 = 32'hC000_0000;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      flush_in;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ROB_W-1:0]  req_rob_id;
    logic [NUM_REQ*DATA_W-1:0] req_value;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ROB_W-1:0]          cdb_rob_id;
    logic [DATA_W-1:0]         cdb_value;
    logic [1:0]                cdb_src;
    logic [1:0]                pending_count;

    always #5 clk_in = ~clk_in;

    cdb_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ROB_W  (ROB_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .flush_in     (flush_in),
        .req_valid    (req_valid),
        .req_rob_id   (req_rob_id),
        .req_value    (req_value),
        .req_ready    (req_ready),
        .cdb_rob_id   (cdb_rob_id),
        .cdb_value    (cdb_value),
        .cdb_src      (cdb_src),
        .pending_count(pending_count)
    );

    typedef struct {
        logic        flush;
        logic [2:0]  valid;
        logic [4:0]  r0, r1, r2;
        logic [2:0]  exp_ready;   // sampled before the edge
        logic [4:0]  exp_rob;     // sampled after the edge
        logic [31:0] exp_val;
        logic [1:0]  exp_src;
        logic [1:0]  exp_pend;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic f, input logic [2:0] v,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        flush_in   = f;
        req_valid  = v;
        req_rob_id = {c, b, a};
        req_value  = {BASE2 + 32'(c), BASE1 + 32'(b), BASE0 + 32'(a)};
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic add(input logic f, input logic [2:0] v,
                       input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                       input logic [2:0] rdy, input logic [4:0] rob,
                       input logic [31:0] val, input logic [1:0] src, input logic [1:0] pend);
        vec_t t;
        t.flush = f;    t.valid = v;      t.r0 = a; t.r1 = b; t.r2 = c;
        t.exp_ready = rdy; t.exp_rob = rob; t.exp_val = val;
        t.exp_src = src;   t.exp_pend = pend;
        vecs.push_back(t);
    endtask

    initial begin
        int e;

        // Single result from ALU.
        add(0, 3'b001,  5, 0, 0, 3'b111,  0, 32'h0000_0000, 0, 1);
        add(0, 3'b000,  0, 0, 0, 3'b111,  5, 32'hA000_0005, 0, 0);
        add(0, 3'b000,  0, 0, 0, 3'b111,  0, 32'hA000_0005, 0, 0);
        // Flush to bring the pointer back to 0, then two three-way collisions.
        add(1, 3'b000,  0, 0, 0, 3'b000,  0, 32'hA000_0005, 0, 0);
        add(0, 3'b111,  3, 4, 6, 3'b111,  0, 32'hA000_0005, 0, 3);
        add(0, 3'b000,  0, 0, 0, 3'b001,  3, 32'hA000_0003, 0, 2);
        add(0, 3'b000,  0, 0, 0, 3'b011,  4, 32'hB000_0004, 1, 1);
        add(0, 3'b111,  7, 8, 9, 3'b111,  6, 32'hC000_0006, 2, 3);
        add(0, 3'b000,  0, 0, 0, 3'b001,  7, 32'hA000_0007, 0, 2);
        add(0, 3'b000,  0, 0, 0, 3'b011,  8, 32'hB000_0008, 1, 1);
        add(0, 3'b000,  0, 0, 0, 3'b111,  9, 32'hC000_0009, 2, 0);
        add(0, 3'b000,  0, 0, 0, 3'b111,  0, 32'hC000_0009, 2, 0);
        // Back-pressure: ALU streams 20.., MEM holds each id until ready.
        add(0, 3'b011, 20, 10, 0, 3'b111,  0, 32'hC000_0009, 2, 2);
        add(0, 3'b011, 21, 11, 0, 3'b101, 20, 32'hA000_0014, 0, 2);
        add(0, 3'b011, 22, 11, 0, 3'b110, 10, 32'hB000_000A, 1, 2);
        add(0, 3'b011, 22, 12, 0, 3'b101, 21, 32'hA000_0015, 0, 2);
        add(0, 3'b011, 23, 12, 0, 3'b110, 11, 32'hB000_000B, 1, 2);
        add(0, 3'b001, 23,  0, 0, 3'b101, 22, 32'hA000_0016, 0, 2);
        add(0, 3'b000,  0,  0, 0, 3'b110, 12, 32'hB000_000C, 1, 1);
        add(0, 3'b000,  0,  0, 0, 3'b111, 23, 32'hA000_0017, 0, 0);
        add(0, 3'b000,  0,  0, 0, 3'b111,  0, 32'hA000_0017, 0, 0);
        // Flush with rob 2 and 9 pending (and new valid requests during the flush).
        add(0, 3'b011,  2,  9, 0, 3'b111,  0, 32'hA000_0017, 0, 2);
        add(1, 3'b111,  2,  9, 2, 3'b000,  0, 32'hA000_0017, 0, 0);
        add(0, 3'b000,  0,  0, 0, 3'b111,  0, 32'hA000_0017, 0, 0);
        add(0, 3'b000,  0,  0, 0, 3'b111,  0, 32'hA000_0017, 0, 0);

        // Reset state, checked while reset is still asserted.
        rst_in = 1'b0;
        drive(0, 3'b000, 0, 0, 0);
        #2;
        check("reset cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        check("reset cdb_value", cdb_value, 32'd0);
        check("reset cdb_src", 32'(cdb_src), 32'd0);
        check("reset pending_count", 32'(pending_count), 32'd0);
        tick();
        tick();
        rst_in = 1'b1;
        #1;
        check("post-reset req_ready", 32'(req_ready), 32'h7);

        foreach (vecs[i]) begin
            drive(vecs[i].flush, vecs[i].valid, vecs[i].r0, vecs[i].r1, vecs[i].r2);
            #1;
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            tick();
            check($sformatf("row%0d cdb_rob_id", i), 32'(cdb_rob_id), 32'(vecs[i].exp_rob));
            check($sformatf("row%0d cdb_value", i), cdb_value, vecs[i].exp_val);
            check($sformatf("row%0d cdb_src", i), 32'(cdb_src), 32'(vecs[i].exp_src));
            check($sformatf("row%0d pending_count", i), 32'(pending_count), 32'(vecs[i].exp_pend));
        end

        // Streaming: ALU alone, rob 1..8 on consecutive cycles.
        for (int k = 1; k <= 10; k++) begin
            if (k <= 8) drive(0, 3'b001, 5'(k), 0, 0);
            else        drive(0, 3'b000, 0, 0, 0);
            #1;
            if (k <= 8) check($sformatf("stream%0d req_ready0", k), 32'(req_ready[0]), 32'd1);
            tick();
            e = (k >= 2 && k <= 9) ? k - 1 : 0;
            check($sformatf("stream%0d cdb_rob_id", k), 32'(cdb_rob_id), 32'(e));
            if (e != 0) begin
                check($sformatf("stream%0d cdb_value", k), cdb_value, BASE0 + 32'(e));
                check($sformatf("stream%0d cdb_src", k), 32'(cdb_src), 32'd0);
            end
        end

        // rob id 0 is handshaken but never held or broadcast.
        drive(0, 3'b001, 0, 0, 0);
        #1;
        check("rob0 req_ready0", 32'(req_ready[0]), 32'd1);
        tick();
        check("rob0 pending_count", 32'(pending_count), 32'd0);
        check("rob0 cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        drive(0, 3'b011, 0, 13, 0);
        tick();
        check("rob0 mix pending_count", 32'(pending_count), 32'd1);
        drive(0, 3'b000, 0, 0, 0);
        tick();
        check("rob0 mix cdb_rob_id", 32'(cdb_rob_id), 32'd13);
        check("rob0 mix cdb_value", cdb_value, 32'hB000_000D);
        check("rob0 mix cdb_src", 32'(cdb_src), 32'd1);
        tick();
        check("rob0 idle cdb_rob_id", 32'(cdb_rob_id), 32'd0);

        // Asynchronous reset in the middle of a burst.
        drive(1, 3'b000, 0, 0, 0);
        tick();
        drive(0, 3'b111, 1, 2, 3);
        tick();
        check("burst pending_count", 32'(pending_count), 32'd3);
        drive(0, 3'b000, 0, 0, 0);
        tick();
        check("burst first cdb_rob_id", 32'(cdb_rob_id), 32'd1);
        tick();
        check("burst second cdb_rob_id", 32'(cdb_rob_id), 32'd2);
        check("burst second cdb_src", 32'(cdb_src), 32'd1);
        check("burst second cdb_value", cdb_value, 32'hB000_0002);
        #3;
        rst_in = 1'b0;
        #1;
        check("async reset cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        check("async reset cdb_value", cdb_value, 32'd0);
        check("async reset cdb_src", 32'(cdb_src), 32'd0);
        check("async reset pending_count", 32'(pending_count), 32'd0);
        #2;
        rst_in = 1'b1;
        tick();
        check("after reset cdb_rob_id", 32'(cdb_rob_id), 32'd0);
        check("after reset pending_count", 32'(pending_count), 32'd0);
        check("after reset req_ready", 32'(req_ready), 32'h7);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between functional units that produce results tagged with ROB ids (ALU, MEM, BCU).
- Each requester gets a one-entry holding slot. Each cycle, a round-robin scheduler picks one occupied slot and broadcasts its (rob_id, value) on the registered CDB outputs.
- The CDB outputs feed the ROB, the reservation stations and the decoder bypass.
- A flush from the ROB discards all pending results.

Parameters:
- NUM_REQ, 3, number of requesters (index 0 = ALU, 1 = MEM, 2 = BCU).
- ROB_W, 5, ROB id width; id 0 means "no entry".
- DATA_W, 32, result value width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; one clock; reset is asynchronous and active-low.
- flush_in  input  1  ROB flush (mispredict); synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester result valid.
- req_rob_id  input  NUM_REQ*ROB_W  flattened ROB ids; requester i occupies bits [i*ROB_W +: ROB_W].
- req_value  input  NUM_REQ*DATA_W  flattened result values, same packing.
- req_ready  output  NUM_REQ  slot i can accept this cycle.
- cdb_rob_id  output  ROB_W  broadcast ROB id; 0 = idle.
- cdb_value  output  DATA_W  broadcast value.
- cdb_src  output  2  index of the granted requester.
- pending_count  output  2  number of occupied slots (0..NUM_REQ).

Behaviour:
- Reset (rst_in=0, asynchronous):
  - all slots empty; rr_ptr=0;
  - cdb_rob_id=0, cdb_value=0, cdb_src=0, pending_count=0.
  - req_ready is combinational; it reads all-1 once reset releases.
- Slot state per i: occ[i], rob[i], val[i].
- Arbitration, combinational, over occupied slots:
  - search order rr_ptr, rr_ptr+1, ... mod NUM_REQ;
  - the first occupied slot wins, giving grant index g and any_grant.
- req_ready[i] = !flush_in && (!occ[i] || (any_grant && g==i)).
  - It does not depend on req_valid, so there is no combinational loop.
- Each rising edge with flush_in=0:
  - If any_grant: cdb_rob_id<=rob[g], cdb_value<=val[g], cdb_src<=g; occ[g] is cleared; rr_ptr<=(g+1) mod NUM_REQ.
  - Otherwise: cdb_rob_id<=0; cdb_value and cdb_src hold; rr_ptr holds.
  - Capture: if req_valid[i] && req_ready[i] && req_rob_id_i!=0, then occ[i]<=1 and the slot loads the id and value. Capture takes priority over the clear for the same slot, so a back-to-back stream from one requester is sustained.
  - req_valid with rob_id 0 is accepted (handshake completes) but discarded.
- Latency:
  - a result accepted at edge E is broadcast at the earliest at edge E+1, visible for exactly one cycle after that edge;
  - each cdb_rob_id pulse lasts 1 cycle per result, with no duplicates.
- Throughput: one broadcast per cycle when any slot is occupied.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,... Worst-case wait from slot occupancy to broadcast is NUM_REQ-1 cycles.
- Flush (flush_in=1 at an edge):
  - all occ cleared; cdb_rob_id<=0; rr_ptr<=0;
  - no capture, no broadcast; req_ready=0 throughout the flush cycle.
- pending_count is registered and equals the popcount of occ after the edge.
- Simultaneous events: grant-clear and new capture on the same slot in one edge leave the slot occupied with the new data.
- Reset asserted mid-transfer drops all slots immediately, asynchronously.

Test Plan:
- Single result: ALU req (rob 5, 0x1234) at cycle 1 → cdb_rob_id=5, cdb_value=0x1234, cdb_src=0 for exactly cycle 3; idle (0) in cycle 4.
- Three-way collision: ALU rob 3, MEM rob 4, BCU rob 6 all valid in one cycle → broadcasts 3, 4, 6 on consecutive cycles. A following collision (rob 7, 8, 9) with rr_ptr=0 is broadcast in rotated order continuing from the pointer.
- Back-pressure:
  - MEM held valid, rob 10,11,12, with ALU continuously valid → req_ready[1] drops while slot 1 waits;
  - no result lost or duplicated;
  - ALU and MEM grants alternate.
- Streaming: ALU alone valid every cycle, rob 1..8 → req_ready[0] stays 1 and the CDB shows 1..8 on 8 consecutive cycles.
- Flush: slots hold rob 2 and rob 9, flush_in pulses one cycle → neither id ever appears on the CDB; pending_count=0; req_ready all 0 during the flush cycle and all 1 afterwards.
- Reset and rob 0:
  - rst_in low mid-stream → CDB outputs 0 immediately, without waiting for a clock edge;
  - a req with rob_id 0 is handshaken but never broadcast.
